btn_pulse_gen: RTL and testbench

- Conditions one raw mechanical push-button (Tang9k on-board key, 27 MHz board clock).
- Produces clean single-cycle event pulses: press, long-press and release. Also produces a debounced level.
- Its oPressPulse is the button-event input that LEDDriver-style consumers sample as a one-cycle strobe (iIntBtn).
- Sits between the top-level pin and every speed/mode-select consumer.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_sync.sv | 24 ++
 rtl/btn_pulse_gen.sv | 129 ++++++++++++
 tb/tb_btn_pulse_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared state encoding and board timing defaults for push-button conditioning.
package btn_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PRESS_DB   = 3'd1;
    localparam logic [2:0] ST_HELD       = 3'd2;
    localparam logic [2:0] ST_LONG_HELD  = 3'd3;
    localparam logic [2:0] ST_RELEASE_DB = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        PRESS_DB   = ST_PRESS_DB,
        HELD       = ST_HELD,
        LONG_HELD  = ST_LONG_HELD,
        RELEASE_DB = ST_RELEASE_DB
    } btn_state_t;

    localparam int DB_10MS = 270000;
    localparam int LONG_1S = 27000000;
    localparam int CLK_HZ  = 27000000;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous pin; both flops reset to the pin's idle level.
module btn_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounces one mechanical button and emits registered press / long-press / release strobes
// plus a debounced active-high level.
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DB_10MS,
    parameter int LONG_PRESS_CYCLES = LONG_1S,
    parameter bit BTN_ACTIVE_LOW    = 1'b1,
    parameter int CNT_W             = 26
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic iBtn,
    output logic oPressPulse,
    output logic oLongPulse,
    output logic oReleasePulse,
    output logic oLevel
);

    localparam logic             PIN_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);

    logic             pin_sync;
    logic             pressed;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             long_seen, long_seen_nxt;
    logic             press_nxt, long_nxt, release_nxt, level_nxt;

    btn_sync #(.RESET_VAL(PIN_IDLE)) u_sync (
        .clk   (CLK),
        .rst_n (RESETn),
        .d     (iBtn),
        .q     (pin_sync)
    );

    assign pressed = BTN_ACTIVE_LOW ? ~pin_sync : pin_sync;

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        long_seen_nxt = long_seen;
        press_nxt     = 1'b0;
        long_nxt      = 1'b0;
        release_nxt   = 1'b0;
        level_nxt     = oLevel;
        unique case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS_DB;
                    cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end else if (cnt == LP_LAST) begin
                    state_nxt     = LONG_HELD;
                    long_seen_nxt = 1'b1;
                    long_nxt      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                // Counter stays frozen here: a long press fires once, never auto-repeats.
                if (!pressed) begin
                    state_nxt = RELEASE_DB;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (pressed) begin
                    state_nxt = long_seen ? LONG_HELD : HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    long_seen_nxt = 1'b0;
                    release_nxt   = 1'b1;
                    level_nxt     = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state         <= IDLE;
            cnt           <= '0;
            long_seen     <= 1'b0;
            oPressPulse   <= 1'b0;
            oLongPulse    <= 1'b0;
            oReleasePulse <= 1'b0;
            oLevel        <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            long_seen     <= long_seen_nxt;
            oPressPulse   <= press_nxt;
            oLongPulse    <= long_nxt;
            oReleasePulse <= release_nxt;
            oLevel        <= level_nxt;
        end
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench: table-driven latency scenarios, directed reset/polarity sequences,
// and random button activity compared against a run-length reference model.
module tb_btn_pulse_gen;

    localparam int DB = 4;
    localparam int LP = 10;
    localparam int NROWS = 40;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_lo = 1'b1;
    logic btn_hi = 1'b0;
    logic press_lo, long_lo, rel_lo, lvl_lo;
    logic press_hi, long_hi, rel_hi, lvl_hi;
    logic [3:0] out_lo, out_hi;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btn_pulse_gen #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .BTN_ACTIVE_LOW(1'b1), .CNT_W(26)) dut (
        .CLK(clk), .RESETn(rst_n), .iBtn(btn_lo),
        .oPressPulse(press_lo), .oLongPulse(long_lo), .oReleasePulse(rel_lo), .oLevel(lvl_lo)
    );

    btn_pulse_gen #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .BTN_ACTIVE_LOW(1'b0), .CNT_W(26)) dut_hi (
        .CLK(clk), .RESETn(rst_n), .iBtn(btn_hi),
        .oPressPulse(press_hi), .oLongPulse(long_hi), .oReleasePulse(rel_hi), .oLevel(lvl_hi)
    );

    assign out_lo = {press_lo, long_lo, rel_lo, lvl_lo};
    assign out_hi = {press_hi, long_hi, rel_hi, lvl_hi};

    typedef struct {
        logic       pin;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[NROWS];

    // Reference model: debounced level flips once the synchronized input has disagreed with
    // it on DB+1 consecutive edges; long fires LP edges after the hold timer (re)starts.
    bit       m_level;
    bit       m_long;
    bit [1:0] m_dly;
    int       m_run;
    int       m_age;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (press,long,release,level)", name, act, exp);
        end
    endtask

    task automatic step(input logic lo, input logic hi);
        btn_lo = lo;
        btn_hi = hi;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_level = 1'b0;
        m_long  = 1'b0;
        m_dly   = 2'b00;
        m_run   = 0;
        m_age   = 0;
    endtask

    task automatic model_edge(input bit pressed, output logic [3:0] exp);
        bit p;
        bit pr, lg, rl;
        pr = 1'b0; lg = 1'b0; rl = 1'b0;
        p = m_dly[1];
        m_dly = {m_dly[0], pressed};
        if (p != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = p;
                m_run = 0;
                if (p) begin
                    pr = 1'b1;
                    m_age = 0;
                end else begin
                    rl = 1'b1;
                    m_long = 1'b0;
                end
            end
        end else begin
            if (m_level && m_run > 0) begin
                m_age = 0;
            end else if (m_level) begin
                m_age++;
                if (m_age == LP && !m_long) begin
                    lg = 1'b1;
                    m_long = 1'b1;
                end
            end
            m_run = 0;
        end
        exp = {pr, lg, rl, m_level};
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        btn_lo = 1'b1;
        btn_hi = 1'b0;
        @(negedge clk);
        check("reset_lo", out_lo, 4'b0000);
        check("reset_hi", out_hi, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0);
    endtask

    // Scenario 0: clean 30-cycle hold then release. Scenario 1: same with a 2-cycle release glitch.
    task automatic fill_table(input int scen);
        for (int i = 0; i < NROWS; i++) begin
            tbl[i].pin = (i < 30) ? 1'b0 : 1'b1;
            if (scen == 1 && (i == 8 || i == 9)) tbl[i].pin = 1'b1;
            tbl[i].exp = {(i == 6), (i == ((scen == 1) ? 22 : 16)), (i == 36), (i >= 6 && i < 36)};
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < NROWS; i++) begin
            step(tbl[i].pin, 1'b0);
            check($sformatf("%s[%0d]", name, i), out_lo, tbl[i].exp);
        end
    endtask

    initial begin
        logic [3:0] exp;
        bit         pressed;
        int         len;
        int         cyc;

        do_reset();

        fill_table(0);
        run_table("long_press");

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                step((i < 3) ? 1'b0 : 1'b1, 1'b0);
                check($sformatf("bounce%0d[%0d]", r, i), out_lo, 4'b0000);
            end
        end
        repeat (2) step(1'b1, 1'b0);

        fill_table(1);
        run_table("glitch");

        // Reset inside PRESS_DB with the counter at 2, button kept held throughout.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("pre_rst_db[%0d]", i), out_lo, 4'b0000);
        end
        rst_n = 1'b0;
        #1;
        check("rst_in_press_db", out_lo, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("held_thru_rst[%0d]", i), out_lo, {(i == 6), 1'b0, 1'b0, (i >= 6)});
        end
        rst_n = 1'b0;
        #1;
        check("rst_in_held", out_lo, 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("held_thru_rst2[%0d]", i), out_lo, {(i == 6), (i == 16), 1'b0, (i >= 6)});
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("release_after_rst[%0d]", i), out_lo, {1'b0, 1'b0, (i == 6), (i < 6)});
        end

        // Active-high pin: idles at 0 with no pulse, then a stable press and release.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("hi_idle[%0d]", i), out_hi, 4'b0000);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("hi_press[%0d]", i), out_hi, {(i == 6), 1'b0, 1'b0, (i >= 6)});
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            check($sformatf("hi_release[%0d]", i), out_hi, {1'b0, 1'b0, (i == 6), (i < 6)});
        end

        // Random activity on both polarities, mirrored pins, against the reference model.
        do_reset();
        model_reset();
        repeat (3) model_edge(1'b0, exp);
        pressed = 1'b0;
        cyc = 0;
        while (cyc < 3000) begin
            pressed = ~pressed;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(LP, LP + 12) : $urandom_range(1, DB + 3);
            for (int i = 0; i < len; i++) begin
                step(~pressed, pressed);
                model_edge(pressed, exp);
                check($sformatf("rand_lo@%0d", cyc), out_lo, exp);
                check($sformatf("rand_hi@%0d", cyc), out_hi, exp);
                cyc++;
            end
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("rand_rst_lo@%0d", cyc), out_lo, 4'b0000);
                check($sformatf("rand_rst_hi@%0d", cyc), out_hi, 4'b0000);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
